// File: rtl/mul_bf16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_bf16_pkg
// Purpose  : Shared types, constants and operand classifier for the BF16
//            multiplier (sign[15], exponent[14:7] bias 127, fraction[6:0]).
// Revision : 1.0 - initial release
// ============================================================================
package mul_bf16_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] frac;
  } bf16_t;

  localparam int unsigned BF16_BIAS    = 127;
  localparam logic [7:0]  BF16_EXP_MAX = 8'hFF;
  localparam logic [15:0] BF16_QNAN    = 16'h7FC0;

  // Denormals fall into ZERO: inputs are flushed before use.
  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } op_class_e;

  function automatic op_class_e bf16_classify(input bf16_t x);
    op_class_e cls;
    if (x.exp == 8'h00) begin
      cls = ZERO;
    end else if (x.exp == BF16_EXP_MAX) begin
      cls = (x.frac == 7'h00) ? INF : NAN;
    end else begin
      cls = NORM;
    end
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_bf16_norm_round.sv
`default_nettype none
// ============================================================================
// Module   : bf16_norm_round
// Purpose  : Normalize a 16-bit significand product, round it to 7 fraction
//            bits and range-check the exponent, producing a packed BF16.
//            MUL_BF16_RNE_EN defined   : round-to-nearest-even.
//            MUL_BF16_RNE_EN undefined : truncate.
// Revision : 1.0 - initial release
// ============================================================================
module bf16_norm_round
  import mul_bf16_pkg::*;
(
  input  logic              sign_in,
  input  logic signed [9:0] exp_in,
  input  logic [15:0]       prod_in,
  output logic [15:0]       result_out,
  output logic              overflow_out,
  output logic              underflow_out
);

  logic [7:0]        mant;
  logic              guard;
  logic              sticky;
  logic signed [9:0] exp_n;
  logic signed [9:0] exp_fin;
  logic [6:0]        frac_fin;

  // Product of two [1,2) significands lies in [1,4); align the leading one.
  always_comb begin
    if (prod_in[15]) begin
      mant   = prod_in[15:8];
      guard  = prod_in[7];
      sticky = |prod_in[6:0];
      exp_n  = exp_in + 10'sd1;
    end else begin
      mant   = prod_in[14:7];
      guard  = prod_in[6];
      sticky = |prod_in[5:0];
      exp_n  = exp_in;
    end
  end

`ifdef MUL_BF16_RNE_EN
  logic       round_up;
  logic [8:0] mant_rnd;

  assign round_up = guard & (sticky | mant[0]);
  assign mant_rnd = {1'b0, mant} + {8'h00, round_up};

  // A carry out of rounding leaves 1.0000000, so renormalize and bump exp.
  always_comb begin
    if (mant_rnd[8]) begin
      frac_fin = mant_rnd[7:1];
      exp_fin  = exp_n + 10'sd1;
    end else begin
      frac_fin = mant_rnd[6:0];
      exp_fin  = exp_n;
    end
  end
`else
  // Truncation: the hidden one and the discarded guard/sticky bits go unused.
  logic trunc_unused;
  assign trunc_unused = guard ^ sticky ^ mant[7];
  assign frac_fin     = mant[6:0];
  assign exp_fin      = exp_n;
`endif

  // Saturate to infinity above the normal range, flush to zero below it.
  always_comb begin
    result_out    = {sign_in, exp_fin[7:0], frac_fin};
    overflow_out  = 1'b0;
    underflow_out = 1'b0;
    if (exp_fin >= 10'sd255) begin
      result_out   = {sign_in, BF16_EXP_MAX, 7'h00};
      overflow_out = 1'b1;
    end else if (exp_fin <= 10'sd0) begin
      result_out    = {sign_in, 15'h0000};
      underflow_out = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_bf16.sv
`default_nettype none
// ============================================================================
// Module   : mul_bf16
// Purpose  : Multi-cycle BF16 multiplier, IDLE->UNPACK->MUL->NORM, result and
//            flags registered with a one-cycle done pulse 3 cycles after the
//            start-sampling edge. Denormals flushed to zero.
//            Optional macro MUL_BF16_RNE_EN selects round-to-nearest-even;
//            without it the product is truncated.
// Revision : 1.0 - initial release
// ============================================================================
module mul_bf16
  import mul_bf16_pkg::*;
(
  input  logic        clk,
  input  logic        nRST,
  input  logic [15:0] bf1_in,
  input  logic [15:0] bf2_in,
  input  logic        start,
  output logic [15:0] bf_out,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid,
  output logic        done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_UNPACK = 2'd1;
  localparam logic [1:0] ST_MUL    = 2'd2;
  localparam logic [1:0] ST_NORM   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              load_en, unpack_en, mul_en, norm_en;

  bf16_t             a_q, a_d, b_q, b_d;
  op_class_e         cls_a_q, cls_a_d, cls_b_q, cls_b_d;
  logic [7:0]        sig_a_q, sig_a_d, sig_b_q, sig_b_d;
  logic              sign_q, sign_d;
  logic signed [9:0] exp_q, exp_d;
  logic [15:0]       prod_q, prod_d;
  logic [15:0]       bf_out_q, bf_out_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              invalid_q, invalid_d;
  logic              done_q, done_d;

  logic [15:0]       nr_result;
  logic              nr_overflow, nr_underflow;
  logic              any_nan, inf_times_zero, any_inf, any_zero;

  bf16_norm_round u_norm_round (
    .sign_in       (sign_q),
    .exp_in        (exp_q),
    .prod_in       (prod_q),
    .result_out    (nr_result),
    .overflow_out  (nr_overflow),
    .underflow_out (nr_underflow)
  );

  // Next-state: start is only honoured in IDLE; the rest is a fixed sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_UNPACK;
      ST_UNPACK: state_d = ST_MUL;
      ST_MUL:    state_d = ST_NORM;
      ST_NORM:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Stage enables decoded from the current state.
  always_comb begin
    load_en   = 1'b0;
    unpack_en = 1'b0;
    mul_en    = 1'b0;
    norm_en   = 1'b0;
    case (state_q)
      ST_IDLE:   load_en   = start;
      ST_UNPACK: unpack_en = 1'b1;
      ST_MUL:    mul_en    = 1'b1;
      ST_NORM:   norm_en   = 1'b1;
      default:   ;
    endcase
  end

  assign any_nan        = (cls_a_q == NAN) || (cls_b_q == NAN);
  assign inf_times_zero = ((cls_a_q == INF) && (cls_b_q == ZERO)) ||
                          ((cls_a_q == ZERO) && (cls_b_q == INF));
  assign any_inf        = (cls_a_q == INF) || (cls_b_q == INF);
  assign any_zero       = (cls_a_q == ZERO) || (cls_b_q == ZERO);

  // Datapath: each stage updates only its own registers; outputs hold otherwise.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    cls_a_d     = cls_a_q;
    cls_b_d     = cls_b_q;
    sig_a_d     = sig_a_q;
    sig_b_d     = sig_b_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    prod_d      = prod_q;
    bf_out_d    = bf_out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    invalid_d   = invalid_q;
    done_d      = 1'b0;

    if (load_en) begin
      a_d = bf1_in;
      b_d = bf2_in;
    end

    if (unpack_en) begin
      cls_a_d = bf16_classify(a_q);
      cls_b_d = bf16_classify(b_q);
      sig_a_d = {1'b1, a_q.frac};
      sig_b_d = {1'b1, b_q.frac};
    end

    if (mul_en) begin
      prod_d = {8'h00, sig_a_q} * {8'h00, sig_b_q};
      sign_d = a_q.sign ^ b_q.sign;
      exp_d  = $signed({2'b00, a_q.exp}) + $signed({2'b00, b_q.exp})
             - $signed(10'(BF16_BIAS));
    end

    if (norm_en) begin
      done_d      = 1'b1;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      invalid_d   = 1'b0;
      if (any_nan || inf_times_zero) begin
        bf_out_d  = BF16_QNAN;
        invalid_d = 1'b1;
      end else if (any_inf) begin
        bf_out_d = {sign_q, BF16_EXP_MAX, 7'h00};
      end else if (any_zero) begin
        bf_out_d = {sign_q, 15'h0000};
      end else begin
        bf_out_d    = nr_result;
        overflow_d  = nr_overflow;
        underflow_d = nr_underflow;
      end
    end
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cls_a_q     <= ZERO;
      cls_b_q     <= ZERO;
      sig_a_q     <= 8'h00;
      sig_b_q     <= 8'h00;
      sign_q      <= 1'b0;
      exp_q       <= 10'sd0;
      prod_q      <= 16'h0000;
      bf_out_q    <= 16'h0000;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      invalid_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cls_a_q     <= cls_a_d;
      cls_b_q     <= cls_b_d;
      sig_a_q     <= sig_a_d;
      sig_b_q     <= sig_b_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      prod_q      <= prod_d;
      bf_out_q    <= bf_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      invalid_q   <= invalid_d;
      done_q      <= done_d;
    end
  end

  assign bf_out    = bf_out_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign invalid   = invalid_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_bf16.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_bf16
// Purpose  : Scoreboard bench for mul_bf16. The driver pushes expected
//            results; a monitor pops and compares on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_bf16;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic [15:0] bf1_in = 16'h0000;
  logic [15:0] bf2_in = 16'h0000;
  logic        start = 1'b0;
  logic [15:0] bf_out;
  logic        overflow, underflow, invalid, done;

`ifdef MUL_BF16_RNE_EN
  localparam logic [15:0] EXP_RND_UP = 16'h491B;
  localparam logic [15:0] EXP_CARRY  = 16'h4000;
`else
  localparam logic [15:0] EXP_RND_UP = 16'h491A;
  localparam logic [15:0] EXP_CARRY  = 16'h3FFF;
`endif

  mul_bf16 dut (
    .clk       (clk),
    .nRST      (nRST),
    .bf1_in    (bf1_in),
    .bf2_in    (bf2_in),
    .start     (start),
    .bf_out    (bf_out),
    .overflow  (overflow),
    .underflow (underflow),
    .invalid   (invalid),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] bf;
    logic [2:0]  fl;     // {overflow, underflow, invalid}
    int          issue;  // cycle of the start-sampling edge
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_done = 0;
  int   saved_done;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (nRST === 1'b1 && done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got bf_out=%h, want no result", bf_out);
      end else begin
        mon_e = sb.pop_front();
        check("bf_out", {16'h0, bf_out}, {16'h0, mon_e.bf});
        check("flags", {29'h0, overflow, underflow, invalid}, {29'h0, mon_e.fl});
        check("latency", cyc - mon_e.issue, 3);
      end
    end
  end

  // Called at a negedge: drive operands and record the expected response.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] e_bf, input logic [2:0] e_fl);
    bf1_in = a;
    bf2_in = b;
    start  = 1'b1;
    sb.push_back('{bf: e_bf, fl: e_fl, issue: cyc + 1});
  endtask

  // Returns at the negedge where done is visible, or reports a timeout.
  task automatic wait_done();
    int t = 0;
    while (done !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (done !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done within %0d cycles, want done", t);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] e_bf, input logic [2:0] e_fl);
    issue(a, b, e_bf, e_fl);
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_bf_out", {16'h0, bf_out}, 32'h0);
    check("rst_flags", {29'h0, overflow, underflow, invalid}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    nRST = 1'b1;
    @(negedge clk);

    // Directed vectors, back-to-back with one idle cycle between results
    run_op(16'h4720, 16'h41C1, 16'h4971, 3'b000);
    run_op(16'h47E0, 16'h40B1, EXP_RND_UP, 3'b000);
    run_op(16'h48F0, 16'h43FA, 16'h4D6A, 3'b000);
    run_op(16'h403F, 16'h3FF3, 16'h40B5, 3'b000);
    run_op(16'h3F92, 16'h3FE0, EXP_CARRY, 3'b000);   // tie on odd LSB, carry-out
    run_op(16'hBFC0, 16'h3F83, 16'hBFC4, 3'b000);   // tie on even LSB stays
    run_op(16'h7F7F, 16'h7F00, 16'h7F80, 3'b100);
    run_op(16'hFF7F, 16'hFF7F, 16'h7F80, 3'b100);
    run_op(16'h3F80, 16'hBF80, 16'hBF80, 3'b000);
    run_op(16'h0080, 16'h0080, 16'h0000, 3'b010);
    run_op(16'h7F80, 16'h0000, 16'h7FC0, 3'b001);
    run_op(16'h7FC1, 16'h3F80, 16'h7FC0, 3'b001);
    run_op(16'hFF80, 16'h4000, 16'hFF80, 3'b000);
    run_op(16'h8000, 16'h3F80, 16'h8000, 3'b000);
    run_op(16'h0001, 16'h4000, 16'h0000, 3'b000);

    // Start held while busy with changing operands must be ignored
    saved_done = n_done;
    issue(16'h4720, 16'h41C1, 16'h4971, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) begin
        bf1_in = 16'($urandom);
        bf2_in = 16'($urandom);
      end
    end
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_single_done", n_done - saved_done, 1);

    // Start held high re-triggers on the edge after returning to IDLE
    issue(16'h3F80, 16'hBF80, 16'hBF80, 3'b000);
    @(negedge clk);
    bf1_in = 16'h4720;
    bf2_in = 16'h41C1;
    sb.push_back('{bf: 16'h4971, fl: 3'b000, issue: cyc + 4});
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset mid-operation: outputs clear and no done follows
    @(negedge clk);
    bf1_in = 16'h4000;
    bf2_in = 16'h4000;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    saved_done = n_done;
    nRST = 1'b0;
    #1;
    check("abort_bf_out", {16'h0, bf_out}, 32'h0);
    check("abort_flags", {29'h0, overflow, underflow, invalid}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    nRST = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_done", n_done - saved_done, 0);

    // Everything issued must have been answered
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mul_bf16.md
Name: mul_bf16

Overview:
- Multi-cycle bfloat16 multiplier: sign[15], exponent[14:7] (bias 127), fraction[6:0].
- Used as the product stage of the systolic-array MAC utilities.
- Accepts one operand pair per start pulse and returns a rounded BF16 product with one-cycle done pulse and exception flags.
- Denormals are flushed (DAZ/FTZ).

Parameters:
- none; format is fixed at BF16, fixed latency 3 cycles.

Ports:
- clk  in  1  rising-edge clock
- nRST  in  1  asynchronous active-low reset
- bf1_in  in  16  operand A, BF16
- bf2_in  in  16  operand B, BF16
- start  in  1  request; operands sampled on the rising edge where start=1 and block idle
- bf_out  out  16  product, valid when done=1, held until next done
- overflow  out  1  result exponent exceeded 254; held with bf_out
- underflow  out  1  nonzero exact product flushed to zero; held with bf_out
- invalid  out  1  NaN operand or inf*0; held with bf_out
- done  out  1  single-cycle pulse marking a new result

Behaviour:
- One clock domain.
- Reset is asynchronous and active-low (nRST).
- While reset is asserted: bf_out=16'h0000, all flags 0, done=0, FSM=IDLE.
- Reset during an operation aborts it; no done is produced.
- FSM: IDLE -> UNPACK -> MUL -> NORM -> IDLE.
- The edge that samples start (in IDLE) loads the operands and enters UNPACK.
- UNPACK: split fields, add hidden 1, classify operands as zero/denorm(=zero)/inf/NaN.
- MUL: 8x8 unsigned significand product (16 bits); sign = A.sign XOR B.sign; exponent = eA + eB - 127, held as signed 10-bit.
- NORM: if product bit15 is set, shift right 1 and increment exponent. Round to 7 fraction bits using guard/sticky, round-to-nearest-even. If rounding carries out, renormalize and increment exponent. Register bf_out/flags and pulse done.
- done is high exactly one cycle, 3 cycles after the start-sampling edge.
- start is ignored when not IDLE.
- start held high re-triggers on the edge after returning to IDLE.
- Special cases, in priority order:
  - Any NaN, or inf*zero: bf_out=16'h7FC0, invalid=1.
  - inf*nonzero: signed inf {s,8'hFF,7'h0}, no flags.
  - zero/denorm input: signed zero, no flags.
  - Final exponent >= 255: signed inf, overflow=1.
  - Final exponent <= 0: signed zero, underflow=1.
- Flags are mutually exclusive and are cleared at each new done.

Optional Feature:
- Macro MUL_BF16_RNE_EN.
- Defined: round-to-nearest-even as above.
- Undefined: truncate (guard/sticky discarded), no rounding carry path. Latency is unchanged.

Decomposition:
- Package mul_bf16_pkg holds:
  - typedef bf16_t (packed struct sign/exp/frac).
  - Constants BF16_BIAS=127, BF16_EXP_MAX=8'hFF, BF16_QNAN=16'h7FC0.
  - Operand class enum (ZERO, NORM, INF, NAN).
- One sub-module, bf16_norm_round: takes sign, signed exponent and 16-bit product; returns packed result plus overflow/underflow. It holds the normalize, round and range-check logic of the NORM stage.

Test Plan:
- 0x4720*0x41C1 -> bf_out 0x4971, no flags, done exactly 3 cycles after start edge.
- 0x47E0*0x40B1 -> 0x491B (RNE round-up); 0x48F0*0x43FA -> 0x4D6A; 0x403F*0x3FF3 -> 0x40B5.
- 0x7F7F*0x7F00 -> 0x7F80, overflow=1; 0xFF7F*0xFF7F -> 0x7F80, overflow=1.
- 0x3F80*0xBF80 -> 0xBF80; 0x0080*0x0080 -> 0x0000, underflow=1.
- 0x7F80*0x0000 -> 0x7FC0, invalid=1; 0x7FC1*0x3F80 -> 0x7FC0, invalid=1.
- Assert nRST mid-operation -> outputs zero, no done. Start pulses while busy are ignored. Back-to-back ops with 1 idle cycle each give correct results.
